axi_write_state_ctrl: RTL and testbench

//  Write-path controller of the AXI interconnect. Decodes AWADDR_M1 and owns the 2-bit W_state that

---
 rtl/axi_write_state_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_axi_write_state_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_state_ctrl.sv
// axi_write_state_ctrl
// Write-path controller for the AXI interconnect. It decodes the master
// write address and owns W_state, which steers the AW, W and B muxes
// for one outstanding write. The transaction runs from AW accept through
// the W burst and the B handshake, and then the path is released.
// Optional feature: define AXI_DEFAULT_SLAVE_EN to add a default slave.
// The default slave answers decode misses and returns DECERR.
module axi_write_state_ctrl #(
    parameter logic [31:0] S0_BASE     = 32'h0000_0000,
    parameter logic [31:0] S1_BASE     = 32'h0001_0000,
    parameter int          REGION_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] AWADDR_M1,
    input  logic [3:0]  AWLEN_M1,
    input  logic        AWVALID_M1,
    input  logic        AWREADY_S0,
    input  logic        AWREADY_S1,
    input  logic        WVALID_M1,
    input  logic        WLAST_M1,
    input  logic        WREADY_S0,
    input  logic        WREADY_S1,
    input  logic        BVALID_S0,
    input  logic        BVALID_S1,
    input  logic        BREADY_M1,
    output logic [1:0]  W_state,
    output logic        W_busy,
    output logic        len_err
`ifdef AXI_DEFAULT_SLAVE_EN
    ,
    output logic        DS_AWREADY,
    output logic        DS_WREADY,
    output logic        DS_BVALID,
    output logic [1:0]  DS_BRESP
`endif
);

    // Transaction phase encoding
    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_ADDR = 2'd1;
    localparam logic [1:0] PH_DATA = 2'd2;
    localparam logic [1:0] PH_RESP = 2'd3;

    // Path steering encoding carried on W_state
    localparam logic [1:0] WS_IDLE = 2'd0;
    localparam logic [1:0] WS_S0   = 2'd1;
    localparam logic [1:0] WS_S1   = 2'd2;
`ifdef AXI_DEFAULT_SLAVE_EN
    localparam logic [1:0] WS_DS   = 2'd3;
`endif

    logic [1:0] phase_q, phase_d;
    logic [1:0] w_state_q, w_state_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic       len_err_q, len_err_d;

    logic s0_hit;
    logic s1_hit;
    logic awready_sel;
    logic wready_sel;
    logic bvalid_sel;

    // Region decode.
    // When both regions match, S0 is tested first and therefore wins.
    assign s0_hit = (AWADDR_M1[31:REGION_BITS] == S0_BASE[31:REGION_BITS]);
    assign s1_hit = (AWADDR_M1[31:REGION_BITS] == S1_BASE[31:REGION_BITS]);

`ifdef AXI_DEFAULT_SLAVE_EN
    logic ds_sel;
    assign ds_sel     = (w_state_q == WS_DS);

    // The default slave accepts the address at once and swallows every beat.
    assign DS_AWREADY = ds_sel && (phase_q == PH_ADDR);
    assign DS_WREADY  = ds_sel && (phase_q == PH_DATA);

    // The default slave always answers with DECERR.
    assign DS_BVALID  = ds_sel && (phase_q == PH_RESP);
    assign DS_BRESP   = DS_BVALID ? 2'b11 : 2'b00;
`endif

    // Select the handshake inputs of the slave that currently owns the path
    always_comb begin
        awready_sel = 1'b0;
        wready_sel  = 1'b0;
        bvalid_sel  = 1'b0;
        case (w_state_q)
            WS_S0: begin
                awready_sel = AWREADY_S0;
                wready_sel  = WREADY_S0;
                bvalid_sel  = BVALID_S0;
            end
            WS_S1: begin
                awready_sel = AWREADY_S1;
                wready_sel  = WREADY_S1;
                bvalid_sel  = BVALID_S1;
            end
            default: begin
                awready_sel = 1'b0;
                wready_sel  = 1'b0;
                bvalid_sel  = 1'b0;
            end
        endcase
`ifdef AXI_DEFAULT_SLAVE_EN
        awready_sel = awready_sel | DS_AWREADY;
        wready_sel  = wready_sel  | DS_WREADY;
        bvalid_sel  = bvalid_sel  | DS_BVALID;
`endif
    end

    // Phase sequencing, target latch, beat counting and length checking
    always_comb begin
        phase_d    = phase_q;
        w_state_d  = w_state_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q;
        case (phase_q)
            PH_IDLE: begin
                if (AWVALID_M1) begin
                    if (s0_hit) begin
                        phase_d   = PH_ADDR;
                        w_state_d = WS_S0;
                    end else if (s1_hit) begin
                        phase_d   = PH_ADDR;
                        w_state_d = WS_S1;
                    end
`ifdef AXI_DEFAULT_SLAVE_EN
                    else begin
                        phase_d   = PH_ADDR;
                        w_state_d = WS_DS;
                    end
`endif
                end
            end
            PH_ADDR: begin
                // The target is already latched, so the address is not decoded again.
                if (AWVALID_M1 && awready_sel) begin
                    phase_d    = PH_DATA;
                    beat_cnt_d = AWLEN_M1;
                end
            end
            PH_DATA: begin
                if (WVALID_M1 && wready_sel) begin
                    if (beat_cnt_q != 4'd0) begin
                        beat_cnt_d = beat_cnt_q - 4'd1;
                    end
                    // WLAST must arrive exactly on the beat where the count reaches zero.
                    if (WLAST_M1 != (beat_cnt_q == 4'd0)) begin
                        len_err_d = 1'b1;
                    end
                    // WLAST still ends the burst, even when a length error was seen.
                    if (WLAST_M1) begin
                        phase_d = PH_RESP;
                    end
                end
            end
            PH_RESP: begin
                if (bvalid_sel && BREADY_M1) begin
                    phase_d   = PH_IDLE;
                    w_state_d = WS_IDLE;
                end
            end
            default: begin
                phase_d   = PH_IDLE;
                w_state_d = WS_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= PH_IDLE;
            w_state_q  <= WS_IDLE;
            beat_cnt_q <= 4'd0;
            len_err_q  <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            w_state_q  <= w_state_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign W_state = w_state_q;
    assign W_busy  = (w_state_q != WS_IDLE);
    assign len_err = len_err_q;

endmodule

// File: tb/tb_axi_write_state_ctrl.sv
// Testbench for axi_write_state_ctrl.
// The stimulus pushes the expected {W_state, W_busy, len_err} value for each
// output change onto a queue. A monitor pops one entry per observed change.
// Point checks cover the cases where the outputs must not change.
module tb_axi_write_state_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] AWADDR_M1 = '0;
    logic [3:0]  AWLEN_M1 = '0;
    logic        AWVALID_M1 = 1'b0;
    logic        AWREADY_S0 = 1'b0;
    logic        AWREADY_S1 = 1'b0;
    logic        WVALID_M1 = 1'b0;
    logic        WLAST_M1 = 1'b0;
    logic        WREADY_S0 = 1'b0;
    logic        WREADY_S1 = 1'b0;
    logic        BVALID_S0 = 1'b0;
    logic        BVALID_S1 = 1'b0;
    logic        BREADY_M1 = 1'b0;
    logic [1:0]  W_state;
    logic        W_busy;
    logic        len_err;
`ifdef AXI_DEFAULT_SLAVE_EN
    logic        DS_AWREADY;
    logic        DS_WREADY;
    logic        DS_BVALID;
    logic [1:0]  DS_BRESP;
`endif

    axi_write_state_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .AWADDR_M1  (AWADDR_M1),
        .AWLEN_M1   (AWLEN_M1),
        .AWVALID_M1 (AWVALID_M1),
        .AWREADY_S0 (AWREADY_S0),
        .AWREADY_S1 (AWREADY_S1),
        .WVALID_M1  (WVALID_M1),
        .WLAST_M1   (WLAST_M1),
        .WREADY_S0  (WREADY_S0),
        .WREADY_S1  (WREADY_S1),
        .BVALID_S0  (BVALID_S0),
        .BVALID_S1  (BVALID_S1),
        .BREADY_M1  (BREADY_M1),
        .W_state    (W_state),
        .W_busy     (W_busy),
        .len_err    (len_err)
`ifdef AXI_DEFAULT_SLAVE_EN
        ,
        .DS_AWREADY (DS_AWREADY),
        .DS_WREADY  (DS_WREADY),
        .DS_BVALID  (DS_BVALID),
        .DS_BRESP   (DS_BRESP)
`endif
    );

    always #5 clk = ~clk;

    int         n_vec  = 0;
    int         n_fail = 0;
    logic [3:0] exp_q[$];
    bit         mon_en = 1'b0;
    bit         mon_primed = 1'b0;
    logic [3:0] mon_prev;

    // Monitor: each change of {W_state, W_busy, len_err} must match the next queued expectation
    always @(negedge clk) begin
        logic [3:0] cur;
        logic [3:0] e;
        cur = {W_state, W_busy, len_err};
        if (mon_en) begin
            if (!mon_primed) begin
                mon_prev   = cur;
                mon_primed = 1'b1;
            end else if (cur !== mon_prev) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got st/busy/err=%b nothing expected at %0t", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_fail++;
                        $display("FAIL transition: got st/busy/err=%b expected %b at %0t", cur, e, $time);
                    end else begin
                        $display("transition st/busy/err=%b at %0t", cur, $time);
                    end
                end
                mon_prev = cur;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ex(input logic [1:0] st, input logic err);
        return {st, (st != 2'd0), err};
    endfunction

    // Runs one complete write to S0 (sl=0) or S1 (sl=1).
    // WREADY can toggle. On toggle runs BVALID/BREADY are held high during DATA.
    // err_beat is the hand-computed beat on which len_err must rise.
    task automatic write_txn(input logic [31:0] addr, input logic [3:0] len, input bit sl,
                             input int nbeats, input int aw_wait, input int b_wait,
                             input bit toggle, input int err_beat, input bit err_before,
                             input bit stray_aw, input string name);
        logic [1:0] st;
        bit         cur_err;
        int         done;
        int         c;
        logic       wr;
        st      = sl ? 2'd2 : 2'd1;
        cur_err = err_before;
        // Address phase
        AWADDR_M1  = addr;
        AWLEN_M1   = len;
        AWVALID_M1 = 1'b1;
        exp_q.push_back(ex(st, cur_err));
        step();
        for (int i = 0; i < aw_wait; i++) step();
        if (sl) AWREADY_S1 = 1'b1; else AWREADY_S0 = 1'b1;
        step();
        AWVALID_M1 = 1'b0;
        AWREADY_S0 = 1'b0;
        AWREADY_S1 = 1'b0;
        // Data phase
        if (toggle) begin
            BREADY_M1 = 1'b1;
            if (sl) BVALID_S1 = 1'b1; else BVALID_S0 = 1'b1;
        end
        done = 0;
        c    = 0;
        while (done < nbeats && c < 64) begin
            wr        = toggle ? logic'(c % 2 == 1) : 1'b1;
            WVALID_M1 = 1'b1;
            WLAST_M1  = (done == nbeats - 1);
            if (sl) WREADY_S1 = wr; else WREADY_S0 = wr;
            if (wr && (done + 1 == err_beat) && !cur_err) begin
                cur_err = 1'b1;
                exp_q.push_back(ex(st, 1'b1));
            end
            step();
            if (wr) done++;
            c++;
        end
        WVALID_M1 = 1'b0;
        WLAST_M1  = 1'b0;
        WREADY_S0 = 1'b0;
        WREADY_S1 = 1'b0;
        // Response phase
        BREADY_M1 = 1'b0;
        if (sl) BVALID_S1 = 1'b1; else BVALID_S0 = 1'b1;
        for (int i = 0; i < b_wait; i++) begin
            if (stray_aw) begin
                AWVALID_M1 = 1'b1;
                AWADDR_M1  = 32'h0001_0000;
            end
            step();
            chk({name, "_hold_state"}, W_state, st);
        end
        exp_q.push_back(ex(2'd0, cur_err));
        BREADY_M1 = 1'b1;
        step();
        AWVALID_M1 = 1'b0;
        BVALID_S0  = 1'b0;
        BVALID_S1  = 1'b0;
        BREADY_M1  = 1'b0;
        step();
        chk({name, "_idle_state"}, W_state, 2'd0);
        chk({name, "_idle_busy"}, W_busy, 1'b0);
        $display("txn %s addr=%h len=%0d beats=%0d done", name, addr, len, nbeats);
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        chk("reset_state", W_state, 2'd0);
        chk("reset_busy", W_busy, 1'b0);
        chk("reset_len_err", len_err, 1'b0);
`ifdef AXI_DEFAULT_SLAVE_EN
        chk("reset_ds", {DS_AWREADY, DS_WREADY, DS_BVALID, DS_BRESP}, 5'd0);
`endif
        rst    = 1'b0;
        mon_en = 1'b1;
        step();

        // 1: single beat to S0, AWREADY arrives after 2 cycles
        write_txn(32'h0000_0100, 4'd0, 1'b0, 1, 2, 0, 1'b0, 0, 1'b0, 1'b0, "t1_s0_single");
        chk("t1_len_err", len_err, 1'b0);

        // 2: 4 beats to S1 with WREADY toggling, B held early must not end DATA
        write_txn(32'h0001_0040, 4'd3, 1'b1, 4, 0, 0, 1'b1, 0, 1'b0, 1'b0, "t2_s1_burst");

        // 3: AWLEN=3 but WLAST on beat 2, so len_err rises and stays set
        write_txn(32'h0000_0200, 4'd3, 1'b0, 2, 0, 0, 1'b0, 2, 1'b0, 1'b0, "t3_short_burst");
        chk("t3_len_err_sticky", len_err, 1'b1);

        // 6: BREADY low for 5 cycles and a stray AW during RESP
        write_txn(32'h0000_0300, 4'd1, 1'b0, 2, 0, 5, 1'b0, 0, 1'b1, 1'b1, "t6_b_stall");
        chk("t6_stray_aw_ignored", W_state, 2'd0);

        // 4: rst during beat 2 of 4
        AWADDR_M1  = 32'h0000_0400;
        AWLEN_M1   = 4'd3;
        AWVALID_M1 = 1'b1;
        AWREADY_S0 = 1'b1;
        exp_q.push_back(ex(2'd1, 1'b1));
        step();
        step();
        AWVALID_M1 = 1'b0;
        AWREADY_S0 = 1'b0;
        WVALID_M1  = 1'b1;
        WREADY_S0  = 1'b1;
        step();
        exp_q.push_back(ex(2'd0, 1'b0));
        rst = 1'b1;
        step();
        rst       = 1'b0;
        WVALID_M1 = 1'b0;
        WREADY_S0 = 1'b0;
        chk("t4_reset_state", W_state, 2'd0);
        chk("t4_reset_len_err", len_err, 1'b0);
        $display("txn t4_mid_burst_reset done");
        step();
        write_txn(32'h0000_0500, 4'd1, 1'b0, 2, 1, 0, 1'b0, 0, 1'b0, 1'b0, "t4_after_reset");
        chk("t4_after_len_err", len_err, 1'b0);

        // 5: address in neither region
        AWADDR_M1  = 32'h0002_0000;
        AWLEN_M1   = 4'd0;
        AWVALID_M1 = 1'b1;
`ifdef AXI_DEFAULT_SLAVE_EN
        exp_q.push_back(ex(2'd3, 1'b0));
        step();
        chk("t5_ds_awready", DS_AWREADY, 1'b1);
        step();
        AWVALID_M1 = 1'b0;
        chk("t5_ds_wready", DS_WREADY, 1'b1);
        WVALID_M1 = 1'b1;
        WLAST_M1  = 1'b1;
        step();
        WVALID_M1 = 1'b0;
        WLAST_M1  = 1'b0;
        chk("t5_ds_bvalid", DS_BVALID, 1'b1);
        chk("t5_ds_bresp", DS_BRESP, 2'b11);
        exp_q.push_back(ex(2'd0, 1'b0));
        BREADY_M1 = 1'b1;
        step();
        BREADY_M1 = 1'b0;
        chk("t5_ds_quiet", {DS_AWREADY, DS_WREADY, DS_BVALID, DS_BRESP}, 5'd0);
`else
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t5_miss_state", W_state, 2'd0);
        end
        AWVALID_M1 = 1'b0;
`endif
        $display("txn t5_decode_miss done");

        step();
        step();
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
